// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory arbiter.
//   dmem_state_e  : controller state (zero-fill sweep, normal service)
//   DMEM_DW       : default data width
//   DMEM_AW       : default address width (depth = 2**DMEM_AW)
//   DMEM_IO_ADDR  : default address whose writes are mirrored to the IO strobe
package dmem_pkg;

    localparam int DMEM_DW = 64;
    localparam int DMEM_AW = 8;

    localparam logic [DMEM_AW-1:0] DMEM_IO_ADDR = 8'hFF;

    typedef enum logic [0:0] {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } dmem_state_e;

endpackage

// File: rtl/dmem_ram.sv
// Single-port synchronous RAM, 2**AW words of DW bits.
//   clk      : clock, posedge
//   we_i     : write enable
//   addr_i   : word address
//   wdata_i  : write data
//   rdata_o  : registered read data (old contents on a write cycle)
// The storage array has no reset; the controller zero-fills it after reset.
module dmem_ram
    import dmem_pkg::*;
#(
    parameter int DW = DMEM_DW,
    parameter int AW = DMEM_AW
) (
    input  logic          clk,
    input  logic          we_i,
    input  logic [AW-1:0] addr_i,
    input  logic [DW-1:0] wdata_i,
    output logic [DW-1:0] rdata_o
);

    logic [DW-1:0] mem_q [2**AW];
    logic [DW-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[addr_i] <= wdata_i;
        end
        rdata_q <= mem_q[addr_i];
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/dmem_arbiter.sv
// Data-memory owner shared by NREQ requesters with round-robin arbitration.
//   clk        : clock, posedge
//   rst        : asynchronous reset, active-low
//   req_valid  : per-requester request present
//   req_we     : per-requester write (1) / read (0)
//   req_addr   : packed addresses, requester i in [i*AW +: AW]
//   req_wdata  : packed write data, requester i in [i*DW +: DW]
//   req_ready  : one-hot (or zero) accept, same cycle as request
//   rsp_valid  : read data valid for requester i, one cycle after accept
//   rsp_rdata  : shared read data, holds last value between responses
//   io_write   : pulse, a write to IO_ADDR was accepted last cycle
//   io_data    : data of that write, zero otherwise
//   init_busy  : zero-fill sweep in progress
//
// state   | meaning
// --------+-----------------------------------------------------------
// ST_INIT | sweep writes 0 to every address, one per cycle; no grants
// ST_RUN  | round-robin service of requesters, one access per cycle
module dmem_arbiter
    import dmem_pkg::*;
#(
    parameter int            NREQ    = 2,
    parameter int            DW      = DMEM_DW,
    parameter int            AW      = DMEM_AW,
    parameter logic [AW-1:0] IO_ADDR = AW'(DMEM_IO_ADDR)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NREQ-1:0]    req_valid,
    input  logic [NREQ-1:0]    req_we,
    input  logic [NREQ*AW-1:0] req_addr,
    input  logic [NREQ*DW-1:0] req_wdata,
    output logic [NREQ-1:0]    req_ready,
    output logic [NREQ-1:0]    rsp_valid,
    output logic [DW-1:0]      rsp_rdata,
    output logic               io_write,
    output logic [DW-1:0]      io_data,
    output logic               init_busy
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    dmem_state_e     state_q, state_d;
    logic [AW-1:0]   cnt_q, cnt_d;
    logic [PW-1:0]   rr_q, rr_d;
    logic [NREQ-1:0] rsp_valid_q, rsp_valid_d;
    logic [DW-1:0]   rdata_hold_q, rdata_hold_d;
    logic            io_write_q, io_write_d;
    logic [DW-1:0]   io_data_q, io_data_d;

    logic [NREQ-1:0] grant;
    logic            found;
    logic [PW-1:0]   win_idx;
    logic [PW:0]     scan_idx;
    logic            win_we;
    logic [AW-1:0]   win_addr;
    logic [DW-1:0]   win_wdata;

    logic            ram_we;
    logic [AW-1:0]   ram_addr;
    logic [DW-1:0]   ram_wdata;
    logic [DW-1:0]   ram_rdata;

    // Scan starts at rr_q and wraps modulo NREQ; NREQ need not be a power of two.
    always_comb begin
        grant    = '0;
        found    = 1'b0;
        win_idx  = '0;
        scan_idx = '0;
        if (state_q == ST_RUN) begin
            for (int k = 0; k < NREQ; k++) begin
                scan_idx = {1'b0, rr_q} + (PW+1)'(k);
                if (scan_idx >= (PW+1)'(NREQ)) begin
                    scan_idx = scan_idx - (PW+1)'(NREQ);
                end
                if (!found && req_valid[scan_idx[PW-1:0]]) begin
                    found   = 1'b1;
                    win_idx = scan_idx[PW-1:0];
                end
            end
            if (found) begin
                grant[win_idx] = 1'b1;
            end
        end
    end

    always_comb begin
        win_we    = 1'b0;
        win_addr  = '0;
        win_wdata = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (grant[k]) begin
                win_we    = req_we[k];
                win_addr  = req_addr[k*AW +: AW];
                win_wdata = req_wdata[k*DW +: DW];
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        rr_d         = rr_q;
        rsp_valid_d  = '0;
        // Latch the RAM output while a response is presented so it can be held afterwards.
        rdata_hold_d = (|rsp_valid_q) ? ram_rdata : rdata_hold_q;
        io_write_d   = 1'b0;
        io_data_d    = '0;
        ram_we       = 1'b0;
        ram_addr     = win_addr;
        ram_wdata    = win_wdata;

        case (state_q)
            ST_INIT: begin
                ram_we    = 1'b1;
                ram_addr  = cnt_q;
                ram_wdata = '0;
                cnt_d     = cnt_q + AW'(1);
                if (cnt_q == '1) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (found) begin
                    ram_we = win_we;
                    rr_d   = (win_idx == PW'(NREQ-1)) ? '0 : win_idx + PW'(1);
                    if (win_we) begin
                        if (win_addr == IO_ADDR) begin
                            io_write_d = 1'b1;
                            io_data_d  = win_wdata;
                        end
                    end else begin
                        rsp_valid_d = grant;
                    end
                end
            end
            default: begin
                state_d = ST_INIT;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= ST_INIT;
            cnt_q        <= '0;
            rr_q         <= '0;
            rsp_valid_q  <= '0;
            rdata_hold_q <= '0;
            io_write_q   <= 1'b0;
            io_data_q    <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            rr_q         <= rr_d;
            rsp_valid_q  <= rsp_valid_d;
            rdata_hold_q <= rdata_hold_d;
            io_write_q   <= io_write_d;
            io_data_q    <= io_data_d;
        end
    end

    dmem_ram #(
        .DW (DW),
        .AW (AW)
    ) u_ram (
        .clk     (clk),
        .we_i    (ram_we),
        .addr_i  (ram_addr),
        .wdata_i (ram_wdata),
        .rdata_o (ram_rdata)
    );

    assign req_ready = grant;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = (|rsp_valid_q) ? ram_rdata : rdata_hold_q;
    assign io_write  = io_write_q;
    assign io_data   = io_data_q;
    assign init_busy = (state_q == ST_INIT);

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed scenarios plus randomized traffic, all
// checked against a behavioural model (flat memory array, integer rr pointer,
// sweep cycle countdown).
module tb_dmem_arbiter;

    localparam int NREQ = 2;
    localparam int DW   = 64;
    localparam int AW   = 8;

    logic               clk = 1'b0;
    logic               rst;
    logic [NREQ-1:0]    req_valid;
    logic [NREQ-1:0]    req_we;
    logic [NREQ*AW-1:0] req_addr;
    logic [NREQ*DW-1:0] req_wdata;
    logic [NREQ-1:0]    req_ready;
    logic [NREQ-1:0]    rsp_valid;
    logic [DW-1:0]      rsp_rdata;
    logic               io_write;
    logic [DW-1:0]      io_data;
    logic               init_busy;

    always #5 clk = ~clk;

    dmem_arbiter #(
        .NREQ    (NREQ),
        .DW      (DW),
        .AW      (AW),
        .IO_ADDR (8'hFF)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_ready (req_ready),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .io_write  (io_write),
        .io_data   (io_data),
        .init_busy (init_busy)
    );

    int vectors    = 0;
    int miscompares = 0;

    logic [DW-1:0]   m_mem [256];
    int              m_rr;
    int              m_sweep;
    logic [NREQ-1:0] m_rv;
    logic [DW-1:0]   m_rdata;
    logic            m_io;
    logic [DW-1:0]   m_iodata;
    int              m_last_w;
    int              g_cnt [NREQ];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_rr     = 0;
        m_sweep  = 256;
        m_rv     = '0;
        m_rdata  = '0;
        m_io     = 1'b0;
        m_iodata = '0;
        m_last_w = -1;
        for (int i = 0; i < 256; i++) m_mem[i] = '0;
    endtask

    task automatic drive(input int r, input logic v, input logic we,
                         input logic [AW-1:0] a, input logic [DW-1:0] d);
        req_valid[r]            = v;
        req_we[r]               = we;
        req_addr[r*AW +: AW]    = a;
        req_wdata[r*DW +: DW]   = d;
    endtask

    task automatic check_reset_outputs();
        chk("rst_req_ready", req_ready, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rsp_rdata", rsp_rdata, 0);
        chk("rst_io_write", io_write, 0);
        chk("rst_io_data", io_data, 0);
        chk("rst_init_busy", init_busy, 1);
    endtask

    // Called at a negedge with inputs already driven; checks, advances the model
    // by one clock, and returns at the next negedge.
    task automatic step();
        int              w;
        int              idx;
        logic [NREQ-1:0] er;
        logic [AW-1:0]   a;
        logic [DW-1:0]   wd;
        #1;
        w  = -1;
        er = '0;
        if (m_sweep == 0) begin
            for (int k = 0; k < NREQ; k++) begin
                idx = (m_rr + k) % NREQ;
                if (w < 0 && req_valid[idx]) w = idx;
            end
        end
        if (w >= 0) er[w] = 1'b1;
        chk("req_ready", req_ready, er);
        chk("ready_onehot", ($countones(req_ready) <= 1), 1);
        chk("rsp_valid", rsp_valid, m_rv);
        chk("rsp_rdata", rsp_rdata, m_rdata);
        chk("io_write", io_write, m_io);
        chk("io_data", io_data, m_iodata);
        chk("init_busy", init_busy, (m_sweep != 0));
        for (int r = 0; r < NREQ; r++) if (req_ready[r]) g_cnt[r]++;

        m_rv     = '0;
        m_io     = 1'b0;
        m_iodata = '0;
        if (w >= 0) begin
            a  = req_addr[w*AW +: AW];
            wd = req_wdata[w*DW +: DW];
            if (req_we[w]) begin
                m_mem[a] = wd;
                if (a == 8'hFF) begin
                    m_io     = 1'b1;
                    m_iodata = wd;
                end
            end else begin
                m_rv[w] = 1'b1;
                m_rdata = m_mem[a];
            end
            m_rr = (w + 1) % NREQ;
        end
        m_last_w = w;
        if (m_sweep > 0) m_sweep--;
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            req_valid = '0;
            step();
        end
    endtask

    task automatic one_shot(input int r, input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
        req_valid = '0;
        drive(r, 1'b1, we, a, d);
        step();
        req_valid = '0;
    endtask

    // A requester keeps its request stable until accepted, then picks a new one.
    task automatic rand_phase(input int n, input bit always_on);
        for (int i = 0; i < n; i++) begin
            for (int r = 0; r < NREQ; r++) begin
                if (m_last_w == r || !req_valid[r]) begin
                    drive(r,
                          always_on ? 1'b1 : 1'($urandom_range(0, 3) != 0),
                          1'($urandom_range(0, 1)),
                          ($urandom_range(0, 7) == 0) ? 8'hFF : 8'($urandom_range(0, 15)),
                          {$urandom, $urandom});
                end
            end
            step();
        end
    endtask

    initial begin
        rst       = 1'b0;
        req_valid = '0;
        req_we    = '0;
        req_addr  = '0;
        req_wdata = '0;
        model_reset();

        @(negedge clk);
        check_reset_outputs();
        rst = 1'b1;

        // Sweep with no requests, then read back a swept location.
        idle(256);
        chk("busy_after_sweep", init_busy, 0);
        one_shot(0, 1'b0, 8'h10, '0);
        idle(1);

        // Write then read back.
        one_shot(0, 1'b1, 8'h10, 64'h1234);
        one_shot(0, 1'b0, 8'h10, '0);
        idle(2);

        // IO write-through and readback.
        one_shot(1, 1'b1, 8'hFF, 64'hDEADBEEF_CAFEF00D);
        idle(1);
        one_shot(0, 1'b0, 8'hFF, '0);
        idle(2);

        // Both requesters always valid: strict alternation.
        for (int r = 0; r < NREQ; r++) g_cnt[r] = 0;
        rand_phase(40, 1'b1);
        chk("grants_req0", g_cnt[0], 20);
        chk("grants_req1", g_cnt[1], 20);

        // Mixed random traffic.
        req_valid = '0;
        m_last_w  = -1;
        rand_phase(400, 1'b0);

        // Reset at the start and in the middle of a sweep.
        req_valid = '0;
        rst = 1'b0;
        #1;
        check_reset_outputs();
        model_reset();
        @(negedge clk);
        rst = 1'b1;
        idle(100);
        rst = 1'b0;
        drive(0, 1'b1, 1'b0, 8'hFF, '0);
        drive(1, 1'b1, 1'b0, 8'h10, '0);
        #1;
        check_reset_outputs();
        model_reset();
        @(negedge clk);
        rst = 1'b1;

        // Requests held through the whole sweep; first grant is requester 0.
        rand_phase(256, 1'b1);
        chk("first_run_ready", req_ready, 2'b01);
        rand_phase(30, 1'b1);
        req_valid = '0;
        idle(2);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
